// File: rtl/kernel_exec_timer_if.sv
// Handshake and statistics bundle between Carus control and the execution timer.
interface kernel_exec_timer_if #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned RUN_CNT_W = 16
);
  logic                 clear_i;
  logic                 start_i;
  logic                 done_i;
  logic                 busy_o;
  logic                 meas_valid_o;
  logic [CNT_W-1:0]     meas_cycles_o;
  logic [CNT_W-1:0]     min_cycles_o;
  logic [CNT_W-1:0]     max_cycles_o;
  logic [RUN_CNT_W-1:0] run_cnt_o;
  logic                 overflow_o;
  logic                 timeout_o;

  // Carus / monitor side: drives control levels, observes statistics
  modport master (
    output clear_i, start_i, done_i,
    input  busy_o, meas_valid_o, meas_cycles_o, min_cycles_o, max_cycles_o,
    input  run_cnt_o, overflow_o, timeout_o
  );

  // Timer side
  modport slave (
    input  clear_i, start_i, done_i,
    output busy_o, meas_valid_o, meas_cycles_o, min_cycles_o, max_cycles_o,
    output run_cnt_o, overflow_o, timeout_o
  );
endinterface

// File: rtl/kernel_exec_timer.sv
// Cycle-exact execution timer: measures start-rise to done-rise distance per run and
// keeps last/min/max/run-count statistics plus sticky overflow and timeout flags.
module kernel_exec_timer #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned RUN_CNT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input logic                clk_i,
  input logic                rst_ni,
  kernel_exec_timer_if.slave bus
);

  localparam logic [CNT_W-1:0]     CntMax     = '1;
  localparam logic [RUN_CNT_W-1:0] RunMax     = '1;
  localparam logic [CNT_W-1:0]     TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  localparam bit                   TimeoutEn  = (TIMEOUT_CYCLES != 0);

  typedef enum logic {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic                 start_q, done_q;
  logic                 start_rise, done_rise;
  logic                 run_end, run_timeout;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     meas_q, meas_d;
  logic [CNT_W-1:0]     min_q, min_d;
  logic [CNT_W-1:0]     max_q, max_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 tmo_q, tmo_d;

  assign start_rise = bus.start_i & ~start_q;
  assign done_rise  = bus.done_i & ~done_q;

  // Edge-detect registers keep tracking inputs even during clear, so no false rise after it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= bus.start_i;
      done_q  <= bus.done_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; done rise beats timeout, start rise in RUN is dropped
  always_comb begin
    state_d     = state_q;
    run_end     = 1'b0;
    run_timeout = 1'b0;
    if (bus.clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_rise) state_d = StRun;
        end
        StRun: begin
          if (done_rise) begin
            state_d = StIdle;
            run_end = 1'b1;
          end else if (TimeoutEn && (cnt_q == TimeoutVal)) begin
            state_d     = StIdle;
            run_timeout = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next values: counter, measurement and statistics
  always_comb begin
    cnt_d     = cnt_q;
    meas_d    = meas_q;
    min_d     = min_q;
    max_d     = max_q;
    run_cnt_d = run_cnt_q;
    valid_d   = run_end;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q | run_timeout;
    if (bus.clear_i) begin
      cnt_d     = '0;
      meas_d    = '0;
      min_d     = CntMax;
      max_d     = '0;
      run_cnt_d = '0;
      valid_d   = 1'b0;
      ovf_d     = 1'b0;
      tmo_d     = 1'b0;
    end else if (state_q == StIdle) begin
      if (start_rise) cnt_d = CNT_W'(1);
    end else if (run_end) begin
      meas_d = cnt_q;
      if (cnt_q < min_q) min_d = cnt_q;
      if (cnt_q > max_q) max_d = cnt_q;
      if (run_cnt_q != RunMax) run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
    end else if (!run_timeout) begin
      if (cnt_q == CntMax) ovf_d = 1'b1;
      else                 cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      meas_q    <= '0;
      min_q     <= CntMax;
      max_q     <= '0;
      run_cnt_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      meas_q    <= meas_d;
      min_q     <= min_d;
      max_q     <= max_d;
      run_cnt_q <= run_cnt_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
    end
  end

  // Outputs come straight from flops
  always_comb begin
    bus.busy_o        = (state_q == StRun);
    bus.meas_valid_o  = valid_q;
    bus.meas_cycles_o = meas_q;
    bus.min_cycles_o  = min_q;
    bus.max_cycles_o  = max_q;
    bus.run_cnt_o     = run_cnt_q;
    bus.overflow_o    = ovf_q;
    bus.timeout_o     = tmo_q;
  end

endmodule

// File: tb/tb_kernel_exec_timer.sv
// Directed bench for kernel_exec_timer: default instance, 8-bit counter instance and
// 50-cycle timeout instance all share the same stimulus.
module tb_kernel_exec_timer;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   a_pulses = 0;

  kernel_exec_timer_if #(.CNT_W(32), .RUN_CNT_W(16)) if_a ();
  kernel_exec_timer_if #(.CNT_W(8),  .RUN_CNT_W(16)) if_b ();
  kernel_exec_timer_if #(.CNT_W(32), .RUN_CNT_W(16)) if_c ();

  kernel_exec_timer #(.CNT_W(32), .RUN_CNT_W(16), .TIMEOUT_CYCLES(0)) dut_a (
    .clk_i (clk), .rst_ni(rst_n), .bus(if_a.slave)
  );
  kernel_exec_timer #(.CNT_W(8), .RUN_CNT_W(16), .TIMEOUT_CYCLES(0)) dut_b (
    .clk_i (clk), .rst_ni(rst_n), .bus(if_b.slave)
  );
  kernel_exec_timer #(.CNT_W(32), .RUN_CNT_W(16), .TIMEOUT_CYCLES(50)) dut_c (
    .clk_i (clk), .rst_ni(rst_n), .bus(if_c.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (if_a.meas_valid_o === 1'b1) a_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic d, input logic c);
    if_a.start_i = s; if_a.done_i = d; if_a.clear_i = c;
    if_b.start_i = s; if_b.done_i = d; if_b.clear_i = c;
    if_c.start_i = s; if_c.done_i = d; if_c.clear_i = c;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start rise this cycle, done rise len cycles later; returns in the cycle after done
  task automatic run(input int len);
    drive(1'b1, 1'b0, 1'b0);
    tick(len);
    drive(1'b1, 1'b1, 1'b0);
    tick(1);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
    tick(1);
  endtask

  task automatic clear();
    drive(1'b0, 1'b0, 1'b1);
    tick(1);
    drive(1'b0, 1'b0, 1'b0);
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #12;
    check("rst_busy",     64'(if_a.busy_o),        64'd0);
    check("rst_valid",    64'(if_a.meas_valid_o),  64'd0);
    check("rst_meas",     64'(if_a.meas_cycles_o), 64'd0);
    check("rst_min",      64'(if_a.min_cycles_o),  64'hFFFF_FFFF);
    check("rst_min_b",    64'(if_b.min_cycles_o),  64'hFF);
    check("rst_max",      64'(if_a.max_cycles_o),  64'd0);
    check("rst_run_cnt",  64'(if_a.run_cnt_o),     64'd0);
    check("rst_overflow", 64'(if_b.overflow_o),    64'd0);
    check("rst_timeout",  64'(if_c.timeout_o),     64'd0);
    #11 rst_n = 1'b1;
    tick(2);

    // Single 100-cycle run
    drive(1'b1, 1'b0, 1'b0);
    tick(1);
    check("t1_busy_first", 64'(if_a.busy_o), 64'd1);
    tick(99);
    check("t1_busy_last",  64'(if_a.busy_o), 64'd1);
    check("t1_no_valid",   64'(if_a.meas_valid_o), 64'd0);
    drive(1'b1, 1'b1, 1'b0);
    tick(1);
    check("t1_valid",   64'(if_a.meas_valid_o),  64'd1);
    check("t1_meas",    64'(if_a.meas_cycles_o), 64'd100);
    check("t1_min",     64'(if_a.min_cycles_o),  64'd100);
    check("t1_max",     64'(if_a.max_cycles_o),  64'd100);
    check("t1_run_cnt", 64'(if_a.run_cnt_o),     64'd1);
    check("t1_busy_end",64'(if_a.busy_o),        64'd0);
    idle();
    check("t1_pulse_1cyc", 64'(if_a.meas_valid_o), 64'd0);

    // Statistics over three runs
    run(40);
    check("t2_meas40", 64'(if_a.meas_cycles_o), 64'd40);
    idle();
    run(250);
    check("t2_meas",    64'(if_a.meas_cycles_o), 64'd250);
    check("t2_min",     64'(if_a.min_cycles_o),  64'd40);
    check("t2_max",     64'(if_a.max_cycles_o),  64'd250);
    check("t2_run_cnt", 64'(if_a.run_cnt_o),     64'd3);
    idle();
    check("t2_pulses",  64'(a_pulses), 64'd3);

    // Spurious done in IDLE, repeated start in RUN
    drive(1'b0, 1'b1, 1'b0);
    tick(2);
    check("t3_spur_valid", 64'(if_a.meas_valid_o), 64'd0);
    check("t3_spur_busy",  64'(if_a.busy_o),       64'd0);
    idle();
    drive(1'b1, 1'b0, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0);
    tick(9);
    drive(1'b1, 1'b0, 1'b0);
    tick(1);
    drive(1'b0, 1'b0, 1'b0);
    tick(49);
    drive(1'b0, 1'b1, 1'b0);
    tick(1);
    check("t3_meas",    64'(if_a.meas_cycles_o), 64'd60);
    check("t3_run_cnt", 64'(if_a.run_cnt_o),     64'd4);
    check("t3_min",     64'(if_a.min_cycles_o),  64'd40);
    idle();
    check("t3_pulses",  64'(a_pulses), 64'd4);

    // Timeout at 50 cycles on dut_c
    clear();
    check("t4_clr_run_cnt", 64'(if_a.run_cnt_o), 64'd0);
    check("t4_clr_timeout", 64'(if_c.timeout_o), 64'd0);
    drive(1'b1, 1'b0, 1'b0);
    tick(50);
    check("t4_busy_at50", 64'(if_c.busy_o),    64'd1);
    check("t4_tmo_at50",  64'(if_c.timeout_o), 64'd0);
    tick(1);
    check("t4_busy_after", 64'(if_c.busy_o),       64'd0);
    check("t4_timeout",    64'(if_c.timeout_o),    64'd1);
    check("t4_no_valid",   64'(if_c.meas_valid_o), 64'd0);
    check("t4_run_cnt",    64'(if_c.run_cnt_o),    64'd0);
    check("t4_min_kept",   64'(if_c.min_cycles_o), 64'hFFFF_FFFF);
    idle();
    clear();
    run(50);
    check("t4_race_valid",   64'(if_c.meas_valid_o),  64'd1);
    check("t4_race_meas",    64'(if_c.meas_cycles_o), 64'd50);
    check("t4_race_timeout", 64'(if_c.timeout_o),     64'd0);
    check("t4_race_run_cnt", 64'(if_c.run_cnt_o),     64'd1);
    idle();

    // Counter saturation on the 8-bit instance
    clear();
    run(300);
    check("t5_meas_sat",  64'(if_b.meas_cycles_o), 64'd255);
    check("t5_overflow",  64'(if_b.overflow_o),    64'd1);
    check("t5_meas_wide", 64'(if_a.meas_cycles_o), 64'd300);
    check("t5_ovf_wide",  64'(if_a.overflow_o),    64'd0);
    idle();
    run(10);
    check("t5_meas_short", 64'(if_b.meas_cycles_o), 64'd10);
    check("t5_ovf_sticky", 64'(if_b.overflow_o),    64'd1);
    idle();
    clear();
    check("t5_ovf_clr",  64'(if_b.overflow_o),    64'd0);
    check("t5_meas_clr", 64'(if_b.meas_cycles_o), 64'd0);

    // Clear coinciding with done rise
    run(25);
    idle();
    drive(1'b1, 1'b0, 1'b0);
    tick(20);
    drive(1'b1, 1'b1, 1'b1);
    tick(1);
    check("t6_clr_valid",   64'(if_a.meas_valid_o), 64'd0);
    check("t6_clr_busy",    64'(if_a.busy_o),       64'd0);
    check("t6_clr_run_cnt", 64'(if_a.run_cnt_o),    64'd0);
    check("t6_clr_min",     64'(if_a.min_cycles_o), 64'hFFFF_FFFF);
    check("t6_clr_max",     64'(if_a.max_cycles_o), 64'd0);
    drive(1'b1, 1'b1, 1'b0);
    tick(2);
    check("t6_no_false_rise", 64'(if_a.busy_o), 64'd0);
    idle();

    // Asynchronous reset mid-run
    run(30);
    idle();
    check("t6_pre_run_cnt", 64'(if_a.run_cnt_o), 64'd1);
    drive(1'b1, 1'b0, 1'b0);
    tick(10);
    check("t6_pre_busy", 64'(if_a.busy_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy",    64'(if_a.busy_o),        64'd0);
    check("t6_rst_meas",    64'(if_a.meas_cycles_o), 64'd0);
    check("t6_rst_min",     64'(if_a.min_cycles_o),  64'hFFFF_FFFF);
    check("t6_rst_max",     64'(if_a.max_cycles_o),  64'd0);
    check("t6_rst_run_cnt", 64'(if_a.run_cnt_o),     64'd0);
    drive(1'b0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    tick(2);
    check("t6_post_busy", 64'(if_a.busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
